// File: rtl/uart_pkg.sv
// Shared types and default constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [31:0] TX_ADDR_DEFAULT      = 32'h0000_8000;
  localparam int          CLKS_PER_BIT_DEFAULT = 4;

endpackage

// File: rtl/byte_fifo.sv
// Power-of-two circular byte queue with registered full/empty flags.
// A same-edge push is accepted at full only when a pop frees a slot.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push_s, do_pop_s;

  // Accept/advance decisions and next occupancy
  always_comb begin
    do_pop_s  = pop && !empty_q;
    do_push_s = push && (!full_q || do_pop_s);
    wr_ptr_d  = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == {(AW + 1){1'b0}});
  end

  // Pointer, occupancy and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW + 1){1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TX_ADDR queue bytes that
// the FSM drains back-to-back onto a flop-driven serial line.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] TX_ADDR      = TX_ADDR_DEFAULT,
  parameter int          CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int          DEPTH        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [7:0]  data,
  output logic        tx,
  output logic        busy,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        overflow
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0] BAUD_ZERO = BW'(0);

  tx_state_t   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        overflow_q, overflow_d;

  logic        addr_hit_s;
  logic        baud_end_s;
  logic        fifo_push_s, fifo_pop_s;
  logic        fifo_full_s, fifo_empty_s;
  logic [7:0]  fifo_dout_s;

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   (data),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Store decode; a slot freed by a same-edge pop still admits the byte
  always_comb begin
    addr_hit_s  = data_write && (data_address == TX_ADDR);
    fifo_push_s = addr_hit_s && (!fifo_full_s || fifo_pop_s);
    overflow_d  = overflow_q || (addr_hit_s && fifo_full_s && !fifo_pop_s);
  end

  // Frame sequencer: next state, baud/bit counters, shifter and line level
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_pop_s = 1'b0;
    baud_end_s = (baud_q == BAUD_LAST);
    case (state_q)
      IDLE: begin
        baud_d = BAUD_ZERO;
        bit_d  = 3'd0;
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          shift_d    = fifo_dout_s;
          tx_d       = 1'b0;
          state_d    = START;
        end else begin
          tx_d = 1'b1;
        end
      end
      START: begin
        if (baud_end_s) begin
          baud_d  = BAUD_ZERO;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_end_s) begin
          baud_d = BAUD_ZERO;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_end_s) begin
          baud_d = BAUD_ZERO;
          // Chain straight into the next start bit when more bytes wait
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            shift_d    = fifo_dout_s;
            tx_d       = 1'b0;
            state_d    = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        baud_d  = BAUD_ZERO;
        bit_d   = 3'd0;
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Sequencer and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_q     <= BAUD_ZERO;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_full  = fifo_full_s;
  assign fifo_empty = fifo_empty_s;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: frames are compared cycle by cycle
// against an 8N1 bit pattern derived from the byte pushed.
module tb_mmio_uart_tx;
  localparam int          C   = 4;
  localparam logic [31:0] TXA = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_write;
  logic [31:0] data_address;
  logic [7:0]  data;
  logic        tx, busy, fifo_full, fifo_empty, overflow;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_uart_tx #(
    .TX_ADDR      (TXA),
    .CLKS_PER_BIT (C),
    .DEPTH        (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_write   (data_write),
    .data_address (data_address),
    .data         (data),
    .tx           (tx),
    .busy         (busy),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level i cycles after the start bit first appears
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    int k;
    k = i / C;
    if (k == 0) return 1'b0;
    else if (k >= 9) return 1'b1;
    else return b[k-1];
  endfunction

  task automatic do_reset();
    data_write   = 1'b0;
    data_address = TXA;
    data         = 8'h00;
    reset        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    data_write   = 1'b1;
    data_address = TXA;
    data         = 8'h55;
    tick();
    tick();
    n_cmp++; if (tx !== 1'b1)         begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
    n_cmp++; if (fifo_full !== 1'b0)  begin n_bad++; $display("FAIL reset_full: got %b want 0", fifo_full); end
    n_cmp++; if (overflow !== 1'b0)   begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    data_write = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    data_write = 1'b1; data_address = TXA; data = 8'hA5;
    tick();
    data_write = 1'b0;
    n_cmp++; if (tx !== 1'b1)         begin n_bad++; $display("FAIL single_e0_tx: got %b want 1", tx); end
    n_cmp++; if (fifo_empty !== 1'b0) begin n_bad++; $display("FAIL single_e0_empty: got %b want 0", fifo_empty); end
    tick();
    for (int i = 0; i < 10 * C; i++) begin
      n_cmp++;
      if (tx !== frame_bit(8'hA5, i)) begin
        n_bad++; $display("FAIL single_tx cycle %0d: got %b want %b", i, tx, frame_bit(8'hA5, i));
      end
      if (i == 0 || i == 10 * C - 1) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy cycle %0d: got %b want 1", i, busy); end
      end
      tick();
    end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL single_end_busy: got %b want 0", busy); end
    n_cmp++; if (tx !== 1'b1)         begin n_bad++; $display("FAIL single_end_tx: got %b want 1", tx); end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL single_end_empty: got %b want 1", fifo_empty); end
  endtask

  task automatic test_addr_filter();
    data_write = 1'b1; data_address = 32'h0001_0000; data = 8'hFF;
    tick();
    data_write = 1'b0; data_address = TXA;
    tick();
    n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL filter_empty: got %b want 1", fifo_empty); end
    n_cmp++; if (tx !== 1'b1)         begin n_bad++; $display("FAIL filter_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL filter_busy: got %b want 0", busy); end
    n_cmp++; if (overflow !== 1'b0)   begin n_bad++; $display("FAIL filter_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    data_write = 1'b1; data_address = TXA; data = 8'h01;
    tick();
    data = 8'h02;
    tick();
    data = 8'h03;
    tick();
    data_write = 1'b0;
    for (int f = 0; f < 3; f++) begin
      b = 8'(f + 1);
      for (int i = (f == 0) ? 1 : 0; i < 10 * C; i++) begin
        n_cmp++;
        if (tx !== frame_bit(b, i)) begin
          n_bad++; $display("FAIL b2b_tx frame %0d cycle %0d: got %b want %b", f, i, tx, frame_bit(b, i));
        end
        if (i == 0) begin
          n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_gap frame %0d: busy %b want 1", f, busy); end
        end
        tick();
      end
    end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL b2b_end_busy: got %b want 0", busy); end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL b2b_end_empty: got %b want 1", fifo_empty); end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    do_reset();
    for (int j = 0; j < 10; j++) begin
      data_write = 1'b1; data_address = TXA; data = 8'h10 + 8'(j);
      tick();
      if (j == 8) begin
        n_cmp++; if (fifo_full !== 1'b1) begin n_bad++; $display("FAIL ovf_fill_full: got %b want 1", fifo_full); end
        n_cmp++; if (overflow !== 1'b0)  begin n_bad++; $display("FAIL ovf_fill_ovf: got %b want 0", overflow); end
      end
    end
    data_write = 1'b0;
    n_cmp++; if (fifo_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full: got %b want 1", fifo_full); end
    n_cmp++; if (overflow !== 1'b1)  begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    for (int f = 0; f < 9; f++) begin
      b = 8'h10 + 8'(f);
      for (int i = (f == 0) ? 8 : 0; i < 10 * C; i++) begin
        n_cmp++;
        if (tx !== frame_bit(b, i)) begin
          n_bad++; $display("FAIL ovf_tx frame %0d cycle %0d: got %b want %b", f, i, tx, frame_bit(b, i));
        end
        tick();
      end
    end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL ovf_end_busy: got %b want 0", busy); end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL ovf_end_empty: got %b want 1", fifo_empty); end
    n_cmp++; if (overflow !== 1'b1)   begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int j = 0; j < 9; j++) begin
      data_write = 1'b1; data_address = TXA; data = 8'h20 + 8'(j);
      tick();
    end
    data_write = 1'b0;
    n_cmp++; if (fifo_full !== 1'b1) begin n_bad++; $display("FAIL sim_pre_full: got %b want 1", fifo_full); end
    for (int i = 7; i < 10 * C; i++) begin
      n_cmp++;
      if (tx !== frame_bit(8'h20, i)) begin
        n_bad++; $display("FAIL sim_tx cycle %0d: got %b want %b", i, tx, frame_bit(8'h20, i));
      end
      if (i == 10 * C - 1) begin
        data_write = 1'b1; data = 8'h29;
      end
      tick();
    end
    data_write = 1'b0;
    n_cmp++; if (fifo_full !== 1'b1) begin n_bad++; $display("FAIL sim_full: got %b want 1", fifo_full); end
    n_cmp++; if (overflow !== 1'b0)  begin n_bad++; $display("FAIL sim_ovf: got %b want 0", overflow); end
    for (int i = 0; i < 10 * C; i++) begin
      n_cmp++;
      if (tx !== frame_bit(8'h21, i)) begin
        n_bad++; $display("FAIL sim_next_tx cycle %0d: got %b want %b", i, tx, frame_bit(8'h21, i));
      end
      tick();
    end
  endtask

  task automatic test_midframe_reset();
    do_reset();
    data_write = 1'b1; data_address = TXA; data = 8'hA5;
    tick();
    data = 8'h77;
    tick();
    data_write = 1'b0;
    for (int i = 0; i < 4 * C + 1; i++) begin
      n_cmp++;
      if (tx !== frame_bit(8'hA5, i)) begin
        n_bad++; $display("FAIL mid_pre_tx cycle %0d: got %b want %b", i, tx, frame_bit(8'hA5, i));
      end
      tick();
    end
    n_cmp++; if (tx !== 1'b0)         begin n_bad++; $display("FAIL mid_bit3_tx: got %b want 0", tx); end
    n_cmp++; if (fifo_empty !== 1'b0) begin n_bad++; $display("FAIL mid_pre_empty: got %b want 0", fifo_empty); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1)         begin n_bad++; $display("FAIL mid_rst_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL mid_rst_empty: got %b want 1", fifo_empty); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    data_write = 1'b1; data_address = TXA; data = 8'h3C;
    tick();
    data_write = 1'b0;
    tick();
    for (int i = 0; i < 10 * C; i++) begin
      n_cmp++;
      if (tx !== frame_bit(8'h3C, i)) begin
        n_bad++; $display("FAIL mid_post_tx cycle %0d: got %b want %b", i, tx, frame_bit(8'h3C, i));
      end
      tick();
    end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL mid_end_busy: got %b want 0", busy); end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL mid_end_empty: got %b want 1", fifo_empty); end
  endtask

  initial begin
    reset        = 1'b0;
    data_write   = 1'b0;
    data_address = 32'h0000_0000;
    data         = 8'h00;
    test_reset();
    test_single();
    test_addr_filter();
    test_back_to_back();
    test_overflow();
    test_simultaneous();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter TX_ADDR, default 32'h0000_8000, the store address that targets the transmitter.
REQ-002 Parameter CLKS_PER_BIT, default 4, the number of clk cycles per serial bit; legal values are 2 to 65535.
REQ-003 Parameter DEPTH, default 8, the byte FIFO depth; it is a power of two, 2 to 64.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-006 Port data_write, input, 1 bit: store strobe from the CPU memory stage.
REQ-007 Port data_address, input, 32 bits: byte address of the store.
REQ-008 Port data, input, 8 bits: store byte.
REQ-009 Port tx, output, 1 bit: serial line in 8N1 format; idles high.
REQ-010 Port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-011 Port fifo_full, output, 1 bit: FIFO holds DEPTH bytes.
REQ-012 Port fifo_empty, output, 1 bit: FIFO holds 0 bytes.
REQ-013 Port overflow, output, 1 bit: sticky flag meaning at least one byte was dropped.

Function
REQ-014 A push SHALL occur on a rising edge where data_write=1, data_address==TX_ADDR (exact 32-bit compare) and the FIFO is not full after any same-edge pop.
REQ-015 A store to any other address SHALL be ignored and SHALL leave all state unchanged.
REQ-016 A matching store while full with no same-edge pop SHALL be dropped and SHALL set overflow=1.
REQ-017 overflow SHALL stay set until reset.
REQ-018 A same-edge push and pop SHALL leave the occupancy unchanged, including at full and at empty-with-bypass-disallowed.
REQ-019 A byte pushed while the FIFO is empty SHALL NOT be popped on the same edge.
REQ-020 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-021 IDLE -> START: on an edge where the FIFO is non-empty, pop the head byte into the shift register and register tx=0.
REQ-022 START -> DATA: after CLKS_PER_BIT cycles.
REQ-023 DATA: shift 8 bits LSB first, each held for CLKS_PER_BIT cycles on a 3-bit bit counter.
REQ-024 DATA -> STOP: after bit 7 completes; tx=1 for CLKS_PER_BIT cycles.
REQ-025 STOP exit: go to START with a pop if the FIFO is non-empty (no idle gap); otherwise go to IDLE.
REQ-026 Latency: a push at edge E0 SHALL give tx=0 after edge E1 when the block was idle and empty.
REQ-027 A frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-028 tx SHALL be driven directly from a flop, with no combinational path from the inputs.
REQ-029 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1 and wrap to 0 on each bit boundary.
REQ-030 The FIFO read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-031 Occupancy SHALL be tracked in a $clog2(DEPTH)+1-bit count.

Reset
REQ-032 While reset=0, asynchronously: tx=1, busy=0, fifo_empty=1, fifo_full=0, overflow=0, state=IDLE, all counters and pointers 0.
REQ-033 A reset asserted mid-frame SHALL abort the frame, restore tx=1 immediately and flush the FIFO.
REQ-034 The first push SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-035 Package uart_pkg SHALL hold the tx_state_t enum (IDLE, START, DATA, STOP) and the default TX_ADDR and CLKS_PER_BIT constants.
REQ-036 The FIFO SHALL be a sub-module byte_fifo (params DEPTH, WIDTH=8) with push, pop, din, dout, full, empty.
REQ-037 The address decode, FSM, baud counter and shift register SHALL live in mmio_uart_tx.

Verification
REQ-038 Single byte: reset; push 8'hA5 to TX_ADDR, CLKS_PER_BIT=4 -> tx low after E1; bits 1,0,1,0,0,1,0,1, 4 cycles each; stop high; busy low 40 cycles after E1.
REQ-039 Address filter: store 8'hFF to 32'h0001_0000 -> fifo_empty stays 1; tx stays 1; overflow 0.
REQ-040 Back-to-back: push 8'h01, 8'h02, 8'h03 on consecutive edges -> three frames with no idle gap (120 cycles); then fifo_empty=1.
REQ-041 Overflow: with DEPTH=8, push 10 bytes on consecutive edges starting idle -> byte 1 popped at E1; bytes 2-9 fill the FIFO; byte 10 dropped; overflow=1; nine frames sent.
REQ-042 Simultaneous: FIFO full when STOP exits with a push on the same edge -> push accepted; fifo_full stays 1; overflow stays 0.
REQ-043 Mid-frame reset: assert reset during DATA bit 3 -> tx=1 within the same cycle; fifo_empty=1; after release, a new byte 8'h3C transmits correctly.
